ahb3lite_apb_bridge: RTL and testbench

- AHB3-Lite slave (responder) that converts each accepted AHB transfer into one APB master access.
- Sits between the AHB3-Lite interconnect and a same-clock APB peripheral segment.
- Single clock domain, no buffering: one outstanding transfer.
- Adds wait states on AHB until the APB access completes, and maps PSLVERR to the two-cycle AHB ERROR response.

---
 rtl/ahb3lite_apb_bridge.sv | 119 +++++++++++
 tb/tb_ahb3lite_apb_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite responder that turns each accepted transfer into a single APB access.
// One transfer outstanding; AHB is stalled until APB completes, and PSLVERR becomes a two-cycle ERROR.
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  localparam int STRB_W = PDATA_SIZE / 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ERR1   = 3'd3;
  localparam logic [2:0] ST_ERR2   = 3'd4;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;

  logic [2:0]            state_q, state_d;
  logic [PADDR_SIZE-1:0] paddr_q;
  logic                  pwrite_q;
  logic [2:0]            pprot_q;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [HDATA_SIZE-1:0] hrdata_q;
  logic                  accept, size_ok, rd_done;

  // A new transfer may only be taken when the previous data phase is finishing.
  assign accept  = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) & HSEL & HREADY & HTRANS[1];
  assign size_ok = (HSIZE <= HSIZE_WORD);
  assign rd_done = (state_q == ST_ACCESS) & PREADY & ~PSLVERR & ~pwrite_q;

  always_comb begin
    pstrb_d = '0;
    if (HWRITE) begin
      case (HSIZE)
        HSIZE_BYTE:  pstrb_d = STRB_W'(1) << HADDR[1:0];
        HSIZE_HWORD: pstrb_d = STRB_W'(3) << {HADDR[1], 1'b0};
        default:     pstrb_d = '1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_d = size_ok ? ST_SETUP : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        paddr_q  <= HADDR[PADDR_SIZE-1:0];
        pwrite_q <= HWRITE;
        pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
        pstrb_q  <= pstrb_d;
      end
      if (rd_done) hrdata_q <= PRDATA;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PPROT     = pprot_q;
  assign PSTRB     = pstrb_q;
  assign PWDATA    = HWDATA;
  assign HRDATA    = hrdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HADDR, HTRANS[0]};
endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed bench for the AHB3-Lite to APB bridge; expectations are queued at issue and checked by monitors.
module tb_ahb3lite_apb_bridge;
  logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HMASTLOCK;
  logic [31:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
  logic [2:0]  HSIZE, HBURST, PPROT;
  logic [3:0]  HPROT, PSTRB;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  PADDR;

  ahb3lite_apb_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr; logic wr; logic [2:0] size; logic [1:0] htrans; logic [3:0] hprot;
    logic [31:0] wdata; int waitc; logic err; logic [31:0] rdata;
    logic [3:0] pstrb; logic [2:0] pprot; logic resp; int waits;
  } vec_t;
  typedef struct { logic resp; logic [31:0] rdata; int waits; } ahb_exp_t;

  vec_t        vq[$];
  vec_t        apbq[$];
  ahb_exp_t    ahbq[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b1;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                     input logic [1:0] htrans, input logic [3:0] hprot, input logic [31:0] wdata,
                     input int waitc, input logic err, input logic [31:0] rdata,
                     input logic [3:0] pstrb, input logic [2:0] pprot, input logic resp,
                     input int waits);
    vec_t v;
    v.addr = addr; v.wr = wr; v.size = size; v.htrans = htrans; v.hprot = hprot;
    v.wdata = wdata; v.waitc = waitc; v.err = err; v.rdata = rdata;
    v.pstrb = pstrb; v.pprot = pprot; v.resp = resp; v.waits = waits;
    vq.push_back(v);
  endtask

  task automatic wait_ready();
    int k = 0;
    forever begin
      @(negedge HCLK);
      if (HREADYOUT) break;
      if (++k > 50) begin
        chk("hreadyout_timeout", {31'd0, HREADYOUT}, 32'd1);
        break;
      end
    end
    @(posedge HCLK); #1;
  endtask

  // Pipelined AHB master: address of beat i overlaps the data phase of beat i-1.
  task automatic run_seq();
    int n = vq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        ahb_exp_t e;
        e.resp  = vq[i].resp;
        e.waits = vq[i].waits;
        e.rdata = (!vq[i].wr && !vq[i].resp) ? vq[i].rdata : last_rd;
        last_rd = e.rdata;
        ahbq.push_back(e);
        if (vq[i].size <= 3'd2) apbq.push_back(vq[i]);
        HSEL = 1'b1; HTRANS = vq[i].htrans; HADDR = vq[i].addr;
        HWRITE = vq[i].wr; HSIZE = vq[i].size; HPROT = vq[i].hprot;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (i > 0) HWDATA = vq[i-1].wdata;
      wait_ready();
    end
    vq.delete();
  endtask

  // APB slave model plus APB-side scoreboard; checks each access at its SETUP cycle.
  vec_t apb_cur;
  int   apb_cnt;
  always @(negedge HCLK) begin
    if (!mon_en || HRESET) begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0BAD0;
    end else if (PSEL && !PENABLE) begin
      if (apbq.size() == 0) chk("apb_unexpected_setup", 32'd1, 32'd0);
      else begin
        apb_cur = apbq.pop_front();
        apb_cnt = apb_cur.waitc;
        chk("apb_paddr", {24'd0, PADDR}, {24'd0, apb_cur.addr[7:0]});
        chk("apb_pwrite", {31'd0, PWRITE}, {31'd0, apb_cur.wr});
        chk("apb_pstrb", {28'd0, PSTRB}, {28'd0, apb_cur.pstrb});
        chk("apb_pprot", {29'd0, PPROT}, {29'd0, apb_cur.pprot});
        if (apb_cur.wr) chk("apb_pwdata", PWDATA, apb_cur.wdata);
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0BAD0;
    end else if (PSEL && PENABLE) begin
      if (apb_cnt == 0) begin
        PREADY = 1'b1; PSLVERR = apb_cur.err; PRDATA = apb_cur.rdata;
      end else begin
        apb_cnt--; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0BAD0;
      end
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0BAD0;
    end
  end

  // AHB-side monitor: pops one expectation per completed data phase.
  logic dph = 1'b0;
  int   lowc = 0;
  always @(negedge HCLK) begin
    if (!mon_en || HRESET) begin
      dph = 1'b0; lowc = 0;
    end else begin
      if (dph) begin
        if (HREADYOUT) begin
          if (ahbq.size() == 0) chk("ahb_unexpected_completion", 32'd1, 32'd0);
          else begin
            ahb_exp_t e;
            e = ahbq.pop_front();
            chk("ahb_hresp", {31'd0, HRESP}, {31'd0, e.resp});
            chk("ahb_hrdata", HRDATA, e.rdata);
            chk("ahb_wait_states", lowc, e.waits);
          end
          dph = 1'b0;
        end else begin
          lowc++;
          if (HRESP && ahbq.size() != 0) chk("ahb_err1_resp", {31'd0, HRESP}, {31'd0, ahbq[0].resp});
        end
      end
      if (HREADYOUT && HSEL && HTRANS[1]) begin
        dph = 1'b1; lowc = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = '0;
    HBURST = '0; HPROT = '0; HTRANS = '0; HMASTLOCK = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_paddr", {24'd0, PADDR}, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rst_pstrb", {28'd0, PSTRB}, 32'd0);
    chk("rst_pprot", {29'd0, PPROT}, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1 HRESET = 1'b0;

    //   addr        wr    size  trans  hprot  wdata          wt err rdata          strb     pprot   resp waits
    add(32'h104, 1'b1, 3'd2, 2'b10, 4'h3, 32'hDEADBEEF, 0, 1'b0, 32'h0,        4'hF,    3'b001, 1'b0, 2);
    add(32'h013, 1'b0, 3'd0, 2'b10, 4'h2, 32'h0,        2, 1'b0, 32'h11223344, 4'h0,    3'b101, 1'b0, 4);
    add(32'h022, 1'b1, 3'd1, 2'b10, 4'h0, 32'h55667788, 0, 1'b0, 32'h0,        4'b1100, 3'b100, 1'b0, 2);
    add(32'h021, 1'b1, 3'd0, 2'b11, 4'h1, 32'h0000AB00, 0, 1'b0, 32'h0,        4'b0010, 3'b000, 1'b0, 2);
    add(32'h030, 1'b1, 3'd2, 2'b10, 4'h3, 32'hCAFEF00D, 0, 1'b1, 32'h0,        4'hF,    3'b001, 1'b1, 3);
    add(32'h040, 1'b0, 3'd3, 2'b10, 4'h0, 32'h0,        0, 1'b0, 32'h0,        4'h0,    3'b100, 1'b1, 1);
    run_seq();

    HSEL = 1'b1; HTRANS = 2'b01;
    @(negedge HCLK);
    chk("busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("busy_hresp", {31'd0, HRESP}, 32'd0);
    chk("busy_psel", {31'd0, PSEL}, 32'd0);
    @(posedge HCLK); #1 HTRANS = 2'b00;
    @(negedge HCLK);
    chk("idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("idle_psel", {31'd0, PSEL}, 32'd0);
    @(posedge HCLK); #1 HSEL = 1'b0;

    add(32'h008, 1'b0, 3'd2, 2'b10, 4'h2, 32'h0,        1, 1'b0, 32'hA5A5C3C3, 4'h0,    3'b101, 1'b0, 3);
    add(32'h003, 1'b1, 3'd0, 2'b10, 4'h0, 32'h000000EE, 0, 1'b0, 32'h0,        4'b1000, 3'b100, 1'b0, 2);
    run_seq();
    chk("ahbq_empty", ahbq.size(), 32'd0);
    chk("apbq_empty", apbq.size(), 32'd0);

    mon_en = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h50; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1 HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
    #2 HRESET = 1'b1;
    #1;
    chk("midrst_psel", {31'd0, PSEL}, 32'd0);
    chk("midrst_penable", {31'd0, PENABLE}, 32'd0);
    chk("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("midrst_hresp", {31'd0, HRESP}, 32'd0);
    chk("midrst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_psel", {31'd0, PSEL}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
